// File: rtl/coord_display_driver_pkg.sv
// Shared constants for the coordinate display driver: digit count and active-low segment patterns.
package coord_display_driver_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned COORD_W    = 32;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import coord_display_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] pattern_c
);

  // Full 0-F decode; blank is only a safe default.
  always_comb begin
    pattern_c = SEG_BLANK;
    case (nibble)
      4'h0: pattern_c = SEG_0;
      4'h1: pattern_c = SEG_1;
      4'h2: pattern_c = SEG_2;
      4'h3: pattern_c = SEG_3;
      4'h4: pattern_c = SEG_4;
      4'h5: pattern_c = SEG_5;
      4'h6: pattern_c = SEG_6;
      4'h7: pattern_c = SEG_7;
      4'h8: pattern_c = SEG_8;
      4'h9: pattern_c = SEG_9;
      4'hA: pattern_c = SEG_A;
      4'hB: pattern_c = SEG_B;
      4'hC: pattern_c = SEG_C;
      4'hD: pattern_c = SEG_D;
      4'hE: pattern_c = SEG_E;
      4'hF: pattern_c = SEG_F;
      default: pattern_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/coord_display_driver.sv
// Glitch-filters the CPU x/y coordinate taps, snapshots the settled pair and
// scans the low 16 bits of each as hex across an 8-digit multiplexed 7-seg display.
module coord_display_driver
  import coord_display_driver_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned DIGIT_CYCLES  = 100000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [COORD_W-1:0]    xCoord,
  input  logic [COORD_W-1:0]    yCoord,
  input  logic                  freeze,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  update_pulse
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam int unsigned DW = $clog2(DIGIT_CYCLES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX    = DW'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] X_LSD_IDX = IDX_W'(4);
  localparam logic [IDX_W-1:0] Y_LSD_IDX = IDX_W'(0);

  logic [COORD_W-1:0]    cand_x, cand_y;
  logic [COORD_W-1:0]    shown_x, shown_y;
  logic [SW-1:0]         stable_cnt;
  logic [DW-1:0]         div_cnt;
  logic [IDX_W-1:0]      digit_idx;

  logic                  input_changed_c;
  logic                  take_snap_c;
  logic [2*NIB_W*4-1:0]  digit_word_c;
  logic [NIB_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      pattern_c;
  logic                  dp_c;
  logic [NUM_DIGITS-1:0] an_c;

  // Filter/snapshot decisions and the nibble/enable selection for the current scan slot.
  always_comb begin
    input_changed_c = ({xCoord, yCoord} != {cand_x, cand_y});
    take_snap_c     = (stable_cnt == STABLE_MAX) && !freeze &&
                      ({cand_x, cand_y} != {shown_x, shown_y});
    digit_word_c    = {shown_x[15:0], shown_y[15:0]};
    nibble_c        = digit_word_c[{digit_idx, 2'b00} +: NIB_W];
    dp_c            = !(((digit_idx == X_LSD_IDX) && (|shown_x[31:16])) ||
                        ((digit_idx == Y_LSD_IDX) && (|shown_y[31:16])));
    an_c            = (div_cnt == '0) ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble    (nibble_c),
    .pattern_c (pattern_c)
  );

  // Stability window, snapshot registers and the one-shot update strobe.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cand_x       <= '0;
      cand_y       <= '0;
      stable_cnt   <= '0;
      shown_x      <= '0;
      shown_y      <= '0;
      update_pulse <= 1'b0;
    end else begin
      if (input_changed_c) begin
        cand_x     <= xCoord;
        cand_y     <= yCoord;
        stable_cnt <= '0;
      end else if (stable_cnt != STABLE_MAX) begin
        stable_cnt <= stable_cnt + SW'(1);
      end
      update_pulse <= take_snap_c;
      if (take_snap_c) begin
        shown_x <= cand_x;
        shown_y <= cand_y;
      end
    end
  end

  // Digit scan: divider wraps every DIGIT_CYCLES and advances the digit index.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      div_cnt   <= div_cnt + DW'(1);
    end
  end

  // Registered display outputs; all digits blanked on the first cycle of each slot.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_c;
      seg <= pattern_c;
      dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_coord_display_driver.sv
// Scoreboard bench for coord_display_driver with short stability/scan periods.
module tb_coord_display_driver;

  logic        Clk;
  logic        Reset;
  logic [31:0] xCoord;
  logic [31:0] yCoord;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        update_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sb[$];

  coord_display_driver #(
    .STABLE_CYCLES (4),
    .DIGIT_CYCLES  (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .xCoord       (xCoord),
    .yCoord       (yCoord),
    .freeze       (freeze),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .update_pulse (update_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: conventional active-high gfedcba table, inverted.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] hi;
    case (n)
      4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
      4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
      4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
      4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [31:0] x, input logic [31:0] y, input int i);
    logic [31:0] v;
    v = (i >= 4) ? (x >> ((i - 4) * 4)) : (y >> (i * 4));
    return v[3:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Pulse monitor: every strobe must match the next scheduled cycle.
  always @(negedge Clk) begin
    if (update_pulse === 1'b1) begin
      if (sb.size() == 0) chk("pulse_spurious", 32'(update_pulse), 32'd0);
      else                chk("pulse_cyc", cyc, sb.pop_front());
    end
  end

  // Observe 8 full slots; record each digit and count blanked cycles.
  task automatic scan_check(input logic [31:0] x, input logic [31:0] y);
    int         ffc;
    logic [6:0] sg [8];
    logic       dpv[8];
    bit         seen[8];
    bit         found;
    logic       edp;
    ffc = 0;
    for (int i = 0; i < 8; i++) begin
      sg[i] = 7'h7F; dpv[i] = 1'b1; seen[i] = 1'b0;
    end
    for (int c = 0; c < 32; c++) begin
      tick(1);
      if (an === 8'hFF) ffc++;
      else begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (an === ~(8'(1) << i)) begin
            found = 1'b1; seen[i] = 1'b1; sg[i] = seg; dpv[i] = dp;
          end
        end
        if (!found) chk("an_onehot", 32'(an), 32'hFF);
      end
    end
    chk("blank_slots", ffc, 8);
    for (int i = 0; i < 8; i++) begin
      edp = !((i == 4 && x[31:16] != 0) || (i == 0 && y[31:16] != 0));
      chk($sformatf("seen%0d", i), 32'(seen[i]), 32'd1);
      chk($sformatf("seg%0d", i), 32'(sg[i]), 32'(exp_seg(exp_nib(x, y, i))));
      chk($sformatf("dp%0d", i), 32'(dpv[i]), 32'(edp));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_an"},  32'(an), 32'hFF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"},  32'(dp), 32'd1);
    chk({tag, "_pls"}, 32'(update_pulse), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; xCoord = '0; yCoord = '0; freeze = 1'b0;

    for (int r = 0; r < 3; r++) begin
      tick(1);
      chk_reset_outs("rst");
    end
    Reset = 1'b1;
    tick(6);
    scan_check(32'h0, 32'h0);

    // Basic snapshot.
    xCoord = 32'h1234; yCoord = 32'hABCD;
    sb.push_back(cyc + 5);
    tick(8);
    scan_check(32'h1234, 32'hABCD);

    // Glitching x restarts the window; one pulse after it settles.
    xCoord = 32'h5; tick(1);
    xCoord = 32'h6; tick(1);
    xCoord = 32'h5;
    sb.push_back(cyc + 5);
    tick(10);
    scan_check(32'h5, 32'hABCD);

    // Freeze holds the display while the filter keeps running.
    xCoord = 32'h1; yCoord = 32'h2;
    sb.push_back(cyc + 5);
    tick(8);
    freeze = 1'b1;
    xCoord = 32'h9;
    tick(20);
    scan_check(32'h1, 32'h2);
    freeze = 1'b0;
    sb.push_back(cyc + 1);
    tick(6);
    scan_check(32'h9, 32'h2);

    // Upper-half truncation flag on the x LSD.
    xCoord = 32'h0001_0000;
    sb.push_back(cyc + 5);
    tick(8);
    scan_check(32'h0001_0000, 32'h2);

    // Reset mid-window at stable_cnt==2 aborts the pending snapshot.
    xCoord = 32'h77;
    tick(3);
    Reset = 1'b0; xCoord = '0; yCoord = '0;
    tick(1);
    chk_reset_outs("midrst_a");
    tick(1);
    chk_reset_outs("midrst_b");
    Reset = 1'b1;
    tick(10);
    scan_check(32'h0, 32'h0);

    tick(2);
    chk("pulse_missing", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
